// File: rtl/rnn_host_driver.sv
// rnn_host_driver: sequences register-level bus traffic to the RNN accelerator.
// A command is accepted from upstream, latched, and replayed as a short
// series of bus strobes: WRITE is a single register write, STEP launches
// a time-step and polls for idle, INFER launches the dense layer, polls for
// a valid result, reads it back, and offers it on the result handshake.
// Status polls are bounded; running out of polls raises the sticky err flag.
//
// Handshakes: a transfer happens on any rising edge where valid and ready
// are both high; valid may not depend on ready, and once a result is
// offered (res_valid) it and res_data stay stable until res_ready is seen.
module rnn_host_driver #(
    parameter int POLL_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        err,
    input  logic        err_clr,
    output logic [3:0]  dbg_state_o
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WR         = 4'd1;
    localparam logic [3:0] S_STEP_GO    = 4'd2;
    localparam logic [3:0] S_SETTLE     = 4'd3;
    localparam logic [3:0] S_POLL_IDLE  = 4'd4;
    localparam logic [3:0] S_INF_GO     = 4'd5;
    localparam logic [3:0] S_POLL_VALID = 4'd6;
    localparam logic [3:0] S_RD_RES     = 4'd7;
    localparam logic [3:0] S_HOLD       = 4'd8;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_INFER = 2'd2;

    // Counter only needs to reach POLL_LIMIT-1: the read made at that count
    // is the last one allowed.
    localparam int CW = $clog2(POLL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(POLL_LIMIT - 1);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [2:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [15:0]   res_q, res_d;
    logic          err_q, err_d;
    logic          err_set;

    // Upper read-data bits carry nothing this driver uses.
    logic unused_rdata;
    assign unused_rdata = ^m_rdata[31:16];

    // Next-state, command latch, poll counter and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        res_d   = res_q;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    case (cmd_op)
                        OP_WRITE: state_d = S_WR;
                        OP_STEP:  state_d = S_STEP_GO;
                        OP_INFER: state_d = S_INF_GO;
                        default:  err_set = 1'b1;  // reserved op: flag and stay idle
                    endcase
                end
            end
            S_WR:      state_d = S_IDLE;
            S_STEP_GO: state_d = S_SETTLE;
            S_INF_GO:  state_d = S_SETTLE;
            S_SETTLE: begin
                cnt_d   = '0;
                state_d = (op_q == OP_STEP) ? S_POLL_IDLE : S_POLL_VALID;
            end
            S_POLL_IDLE, S_POLL_VALID: begin
                if (m_rdata[0]) begin
                    state_d = (state_q == S_POLL_IDLE) ? S_IDLE : S_RD_RES;
                end else if (cnt_q == LIMIT_M1) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_RES: begin
                res_d   = m_rdata[15:0];
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new error event outranks a clear arriving in the same cycle.
        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 2'd0;
            addr_q  <= 3'd0;
            data_q  <= 32'd0;
            res_q   <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Bus strobes decoded from state; address/data forced to zero when idle.
    always_comb begin
        m_write = 1'b0;
        m_read  = 1'b0;
        m_addr  = 3'd0;
        m_wdata = 32'd0;
        case (state_q)
            S_WR:         begin m_write = 1'b1; m_addr = addr_q; m_wdata = data_q; end
            S_STEP_GO:    begin m_write = 1'b1; m_addr = 3'd0; end
            S_INF_GO:     begin m_write = 1'b1; m_addr = 3'd7; end
            S_POLL_IDLE:  begin m_read  = 1'b1; m_addr = 3'd1; end
            S_POLL_VALID: begin m_read  = 1'b1; m_addr = 3'd0; end
            S_RD_RES:     begin m_read  = 1'b1; m_addr = 3'd7; end
            default:      ;
        endcase
    end

    assign res_valid   = (state_q == S_HOLD);
    assign res_data    = res_q;
    assign busy        = (state_q != S_IDLE);
    assign cmd_ready   = (state_q == S_IDLE) && !res_valid;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rnn_host_driver.sv
// Directed bench for rnn_host_driver with a small accelerator model.
// A second instance with POLL_LIMIT=8 and a status bit that never sets
// exercises the timeout paths.
module tb_rnn_host_driver;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- DUT (default limit) ----------------
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        m_read, m_write;
    logic [2:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic        busy, err, err_clr;
    logic [3:0]  dbg_state;

    rnn_host_driver dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err(err), .err_clr(err_clr), .dbg_state_o(dbg_state)
    );

    // ---------------- DUT (POLL_LIMIT=8, status never set) ----------------
    logic        cmd_valid8, cmd_ready8;
    logic        m_read8, m_write8;
    logic [2:0]  m_addr8;
    logic [31:0] m_wdata8;
    logic [31:0] m_rdata8 = 32'hFFFF_FFFE;
    logic        res_valid8;
    logic        res_ready8 = 1'b0;
    logic [15:0] res_data8;
    logic        busy8, err8, err_clr8;
    logic [3:0]  dbg_state8;

    rnn_host_driver #(.POLL_LIMIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .m_read(m_read8), .m_write(m_write8), .m_addr(m_addr8),
        .m_wdata(m_wdata8), .m_rdata(m_rdata8),
        .res_valid(res_valid8), .res_ready(res_ready8), .res_data(res_data8),
        .busy(busy8), .err(err8), .err_clr(err_clr8), .dbg_state_o(dbg_state8)
    );

    // ---------------- bus activity counters ----------------
    int wr_cnt = 0, rd0_cnt = 0, rd1_cnt = 0, rd7_cnt = 0;
    int rd0_8 = 0, rd1_8 = 0;
    always @(posedge clk) begin
        if (m_write) wr_cnt <= wr_cnt + 1;
        if (m_read && m_addr == 3'd0) rd0_cnt <= rd0_cnt + 1;
        if (m_read && m_addr == 3'd1) rd1_cnt <= rd1_cnt + 1;
        if (m_read && m_addr == 3'd7) rd7_cnt <= rd7_cnt + 1;
        if (m_read8 && m_addr8 == 3'd0) rd0_8 <= rd0_8 + 1;
        if (m_read8 && m_addr8 == 3'd1) rd1_8 <= rd1_8 + 1;
    end

    // ---------------- accelerator model ----------------
    int idle_after = 0, valid_after = 0, rd0_base = 0, rd1_base = 0;
    logic [31:0] res_word = 32'h0;
    always_comb begin
        m_rdata = 32'h0;
        if (m_read) begin
            case (m_addr)
                3'd0:    m_rdata = 32'hFFFF_FFFE | {31'd0, (rd0_cnt - rd0_base) >= valid_after};
                3'd1:    m_rdata = 32'hFFFF_FFFE | {31'd0, (rd1_cnt - rd1_base) >= idle_after};
                3'd7:    m_rdata = res_word;
                default: m_rdata = 32'h0;
            endcase
        end
    end

    // ---------------- scoreboard helpers ----------------
    int checks = 0, errors = 0;
    bit inv_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic inv_check();
        if (inv_en) begin
            chk1("no_rd_wr_overlap", m_read && m_write, 1'b0);
            chk1("no_rd_wr_overlap8", m_read8 && m_write8, 1'b0);
            chk1("ready_vs_busy", cmd_ready && (busy || res_valid), 1'b0);
            chk1("ready_vs_busy8", cmd_ready8 && (busy8 || res_valid8), 1'b0);
            chk1("idle_bus_zero", !m_read && !m_write && (m_addr != 3'd0 || m_wdata != 32'd0), 1'b0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        inv_check();
    endtask

    // Present one command and hold it until accepted (bounded).
    task automatic send_cmd(input bit sel, input logic [1:0] op, input logic [2:0] a, input logic [31:0] d);
        int n;
        cmd_op = op; cmd_addr = a; cmd_data = d;
        if (sel) cmd_valid8 = 1'b1; else cmd_valid = 1'b1;
        n = 0;
        while (!(sel ? cmd_ready8 : cmd_ready) && n < 50) begin
            tick();
            n++;
        end
        chk1("cmd_accept", sel ? cmd_ready8 : cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_valid8 = 1'b0;
        cmd_op = ~op; cmd_addr = ~a; cmd_data = ~d;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n, w0, r0, r1, r7, bus0;
        bit saw_res;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid8 = 1'b0;
        cmd_op = 2'd0; cmd_addr = 3'd0; cmd_data = 32'd0;
        res_ready = 1'b0; err_clr = 1'b0; err_clr8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk1("rst_m_read", m_read, 1'b0);
        chk1("rst_m_write", m_write, 1'b0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk1("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        inv_en = 1'b1;
        tick();

        // WRITE addr 2
        w0 = wr_cnt;
        send_cmd(1'b0, 2'd0, 3'd2, 32'h0103_0100);
        tick();
        chk1("wr_m_write", m_write, 1'b1);
        chk1("wr_m_read", m_read, 1'b0);
        chk("wr_m_addr", 32'(m_addr), 32'd2);
        chk("wr_m_wdata", m_wdata, 32'h0103_0100);
        chk1("wr_busy", busy, 1'b1);
        tick();
        chk1("wr_done_m_write", m_write, 1'b0);
        chk1("wr_done_ready", cmd_ready, 1'b1);
        chk("wr_count", wr_cnt - w0, 32'd1);

        // STEP, idle after 40 polls
        idle_after = 40; rd1_base = rd1_cnt; w0 = wr_cnt;
        send_cmd(1'b0, 2'd1, 3'd5, 32'h1234_5678);
        tick();
        chk1("step_go_write", m_write, 1'b1);
        chk("step_go_addr", 32'(m_addr), 32'd0);
        chk("step_go_wdata", m_wdata, 32'd0);
        tick();
        chk1("step_settle_quiet", m_read || m_write, 1'b0);
        chk1("step_settle_busy", busy, 1'b1);
        tick();
        chk1("step_poll_read", m_read, 1'b1);
        chk("step_poll_addr", 32'(m_addr), 32'd1);
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk("step_poll_reads", rd1_cnt - rd1_base, 32'd41);
        chk("step_writes", wr_cnt - w0, 32'd1);
        chk1("step_idle", busy, 1'b0);
        chk1("step_err", err, 1'b0);

        // INFER, result 16'hFF80 after 3 pending polls
        valid_after = 3; rd0_base = rd0_cnt; r7 = rd7_cnt; res_word = 32'hABCD_FF80;
        send_cmd(1'b0, 2'd2, 3'd0, 32'd0);
        tick();
        chk1("inf_go_write", m_write, 1'b1);
        chk("inf_go_addr", 32'(m_addr), 32'd7);
        chk("inf_go_wdata", m_wdata, 32'd0);
        tick();
        chk1("inf_settle_quiet", m_read || m_write, 1'b0);
        tick();
        chk1("inf_poll_read", m_read, 1'b1);
        chk("inf_poll_addr", 32'(m_addr), 32'd0);
        n = 0;
        while (!res_valid && n < 100) begin tick(); n++; end
        chk1("inf_res_valid", res_valid, 1'b1);
        chk("inf_poll_reads", rd0_cnt - rd0_base, 32'd4);
        chk("inf_result_reads", rd7_cnt - r7, 32'd1);
        res_word = 32'h0000_1111;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk1("hold_res_valid", res_valid, 1'b1);
            chk("hold_res_data", 32'(res_data), 32'h0000_FF80);
            chk1("hold_cmd_ready", cmd_ready, 1'b0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        tick();
        chk1("post_hold_valid", res_valid, 1'b0);
        chk1("post_hold_busy", busy, 1'b0);
        chk("post_hold_data", 32'(res_data), 32'h0000_FF80);
        chk("post_hold_result_reads", rd7_cnt - r7, 32'd1);

        // Reserved op with err_clr in the same cycle: set wins, no bus cycles
        bus0 = wr_cnt + rd0_cnt + rd1_cnt + rd7_cnt;
        err_clr = 1'b1;
        send_cmd(1'b0, 2'd3, 3'd1, 32'hFFFF_FFFF);
        err_clr = 1'b0;
        tick();
        chk1("op3_err", err, 1'b1);
        chk1("op3_busy", busy, 1'b0);
        chk1("op3_quiet", m_read || m_write, 1'b0);
        tick();
        chk("op3_no_bus", wr_cnt + rd0_cnt + rd1_cnt + rd7_cnt - bus0, 32'd0);
        chk1("op3_err_sticky", err, 1'b1);

        // Reset while polling for a result
        valid_after = 1000; rd0_base = rd0_cnt;
        send_cmd(1'b0, 2'd2, 3'd0, 32'd0);
        repeat (5) tick();
        chk1("pv_read", m_read, 1'b1);
        chk("pv_addr", 32'(m_addr), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk1("mid_rst_m_read", m_read, 1'b0);
        chk1("mid_rst_m_write", m_write, 1'b0);
        chk("mid_rst_m_addr", 32'(m_addr), 32'd0);
        chk1("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_res_data", 32'(res_data), 32'd0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_err", err, 1'b0);
        r0 = rd0_cnt;
        repeat (3) tick();
        chk("mid_rst_no_more_reads", rd0_cnt - r0, 32'd0);

        // STEP timeout on the 8-poll instance
        r1 = rd1_8;
        send_cmd(1'b1, 2'd1, 3'd0, 32'd0);
        n = 0;
        tick();
        while (busy8 && n < 60) begin tick(); n++; end
        chk("to_step_reads", rd1_8 - r1, 32'd8);
        chk1("to_step_err", err8, 1'b1);
        chk1("to_step_busy", busy8, 1'b0);
        err_clr8 = 1'b1;
        @(posedge clk);
        #1;
        err_clr8 = 1'b0;
        tick();
        chk1("err_clr", err8, 1'b0);

        // INFER timeout on the 8-poll instance: no result offered
        r0 = rd0_8;
        saw_res = 1'b0;
        send_cmd(1'b1, 2'd2, 3'd0, 32'd0);
        n = 0;
        tick();
        while (busy8 && n < 60) begin
            saw_res = saw_res | res_valid8;
            tick();
            n++;
        end
        chk("to_inf_reads", rd0_8 - r0, 32'd8);
        chk1("to_inf_err", err8, 1'b1);
        chk1("to_inf_no_result", saw_res | res_valid8, 1'b0);
        chk1("to_inf_busy", busy8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rnn_host_driver.md
RNN_HOST_DRIVER -- requirements
Module: rnn_host_driver

Interface
REQ-001 Parameter: POLL_LIMIT, default 4096, max status-poll reads per command before timeout.
REQ-002 Port: clk  input  1  single clock, all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: cmd_valid  input  1  upstream command present.
REQ-005 Port: cmd_ready  output  1  driver accepts command this cycle.
REQ-006 Port: cmd_op  input  2  command: 0 WRITE, 1 STEP, 2 INFER, 3 reserved.
REQ-007 Port: cmd_addr  input  3  accelerator register address (WRITE only).
REQ-008 Port: cmd_data  input  32  write word, {row[31:24], col/index[23:16], Q-value[15:0]} (WRITE only).
REQ-009 Port: m_read, m_write  output  1 each  bus strobes to accelerator.
REQ-010 Port: m_addr  output  3  bus address.
REQ-011 Port: m_wdata  output  32  bus write data.
REQ-012 Port: m_rdata  input  32  bus read data, valid in the same cycle as m_read.
REQ-013 Port: res_valid / res_ready  output / input  1 each  result handshake.
REQ-014 Port: res_data  output  16  signed inference result.
REQ-015 Port: busy  output  1  high whenever state is not IDLE.
REQ-016 Port: err  output  1  sticky timeout/illegal-op flag; err_clr input 1 clears it.

Function
REQ-017 Accelerator register map: write 1-5 tensors, write 6 dense bias, write 0 start step, write 7 start dense; read 0 bit0 = result valid, read 1 bit0 = idle/loading, read 7 = result (read returns it to idle).
REQ-018 States: IDLE, WR, STEP_GO, SETTLE, POLL_IDLE, INF_GO, POLL_VALID, RD_RES, HOLD.
REQ-019 cmd_ready = 1 only in IDLE with res_valid low; transfer on cmd_valid && cmd_ready.
REQ-020 WRITE: IDLE -> WR; WR drives m_write=1, m_addr=cmd_addr, m_wdata=cmd_data for exactly one cycle -> IDLE (2 cycles per write).
REQ-021 STEP: IDLE -> STEP_GO (m_write, addr 0, wdata 0) -> SETTLE (one idle bus cycle) -> POLL_IDLE.
REQ-022 POLL_IDLE: m_read=1, m_addr=1 every cycle; m_rdata[0]=1 -> IDLE.
REQ-023 INFER: IDLE -> INF_GO (m_write, addr 7, wdata 0) -> SETTLE -> POLL_VALID (m_read, addr 0 each cycle); m_rdata[0]=1 -> RD_RES.
REQ-024 RD_RES: one cycle m_read=1, m_addr=7; capture m_rdata[15:0] into res_data; -> HOLD.
REQ-025 HOLD: res_valid=1, res_data stable until res_valid && res_ready -> IDLE next cycle.
REQ-026 Poll counter: cleared on entering a poll state, increments per poll read; reaching POLL_LIMIT with flag still 0 sets err and returns to IDLE; INFER timeout produces no result.
REQ-027 cmd_op=3: accepted, no bus activity, err set, back to IDLE next cycle.
REQ-028 m_read and m_write never high together; m_addr and m_wdata are 0 when no strobe is active.
REQ-029 err_clr clears err next cycle; err set and err_clr in the same cycle: set wins.
REQ-030 cmd_addr/cmd_data/cmd_op registered at acceptance; upstream changes after handshake have no effect.
REQ-031 res_data holds last captured value after HOLD until the next RD_RES.

Reset
REQ-032 rst_n=0 at a rising edge: state IDLE, m_read=m_write=0, m_addr=0, m_wdata=0, res_valid=0, res_data=0, busy=0, err=0, poll counter=0.
REQ-033 Reset mid-operation abandons the command without further bus cycles; the accelerator is not restored (host reissues).

Verification
REQ-034 WRITE op, cmd_addr=2, cmd_data=32'h0103_0100 -> one cycle m_write=1, m_addr=2, m_wdata=32'h0103_0100; cmd_ready high again 2 cycles after handshake.
REQ-035 STEP with model returning idle bit after 40 polls -> write addr 0, 1 settle cycle, exactly 40 reads of addr 1 with bit0=0 then 1 with bit0=1, then IDLE.
REQ-036 INFER, model result 16'hFF80 -> write addr 7, settle, poll addr 0, one read addr 7, res_data=16'hFF80, res_valid held 5 cycles with res_ready=0, cleared after handshake.
REQ-037 STEP with POLL_LIMIT=8 and idle bit never set -> 8 poll reads, err=1, busy=0; err_clr pulse -> err=0.
REQ-038 cmd_op=3 -> no m_read/m_write, err=1; rst_n low during POLL_VALID -> all outputs at reset values next cycle.
REQ-039 Assertion over all tests: never m_read && m_write; cmd_ready=0 whenever busy or res_valid.
